system_memory_v3: RTL and testbench
===================================

// Module: system_memory_v3
// PURPOSE
//  Grid state memory for the Conway engine; successor to the v2 memory.
//  - Holds DATA_SIZE cells; parallel-loaded from the next-state logic in RUN mode.
//  - Serial load and serial dump move LANE_WIDTH bits per clock.
//  - LOAD_DONE / DUMP_DONE pulse when a full frame has been shifted in or out.
// PARAMETERS
//  DATA_SIZE    25  number of grid cells stored
//  LANE_WIDTH    1  serial bits per clock; DATA_SIZE % LANE_WIDTH == 0; BEATS = DATA_SIZE/LANE_WIDTH >= 2
//  COUNT_WIDTH  16  generation counter width (used only with SYSMEM_GEN_COUNT_EN)
// PORTS
//  CLK         in   1            system clock, rising edge
//  RESET_N     in   1            asynchronous, active-low reset
//  GRID_IN     in   DATA_SIZE    next-generation grid from the cell array
//  SERIAL_IN   in   LANE_WIDTH   serial load lane
//  LOAD_MODE   in   1            shift SERIAL_IN into memory
//  RUN_MODE    in   1            parallel load from GRID_IN
//  DUMP_MODE   in   1            rotate memory out through SERIAL_OUT
//  DATA_OUT    out  DATA_SIZE    current memory contents (registered)
//  SERIAL_OUT  out  LANE_WIDTH   mem[DATA_SIZE-1 -: LANE_WIDTH]; combinational from memory
//  LOAD_DONE   out  1            one-cycle pulse: serial frame load complete
//  DUMP_DONE   out  1            one-cycle pulse: serial frame dump complete
//  GEN_COUNT   out  COUNT_WIDTH  RUN loads since reset (only with SYSMEM_GEN_COUNT_EN)
// BEHAVIOUR
//  - Reset (RESET_N=0, async, any time): mem=0, beat_cnt=0, prev_op=IDLE.
//    Outputs go low immediately: DATA_OUT, SERIAL_OUT, LOAD_DONE, DUMP_DONE (and GEN_COUNT).
//  - Op select each edge, priority RUN > LOAD > DUMP > IDLE.
//    Mode inputs are sampled at the edge.
//  - IDLE: mem held; beat_cnt<=0.
//  - RUN: mem<=GRID_IN; beat_cnt<=0. DATA_OUT shows it one cycle after the edge.
//  - LOAD: mem<={mem[DATA_SIZE-LANE_WIDTH-1:0], SERIAL_IN}. Shift left; new lane enters at the LSBs.
//  - DUMP: mem<={mem[DATA_SIZE-LANE_WIDTH-1:0], mem[DATA_SIZE-1 -: LANE_WIDTH]}.
//    This is a rotate left; the MSB lane goes out first.
//    After BEATS dump edges, mem equals its pre-dump value.
//  - Beat counting on a LOAD/DUMP edge:
//    - prev_op != op: beat_cnt<=1. A new frame starts and this edge is beat 1.
//    - prev_op == op, beat_cnt==BEATS-1: beat_cnt<=0 and the matching DONE pulses.
//    - otherwise: beat_cnt++.
//    - prev_op<=op on every edge.
//  - DONE timing: DONE is registered; high exactly one cycle, starting at the edge of the final beat.
//  - Abort: a mode change mid-frame leaves mem as partially shifted and raises no DONE pulse.
//    The next LOAD/DUMP edge restarts the frame at beat 1.
//  - Back-to-back frames: mode held continuously gives a DONE pulse every BEATS edges.
//  - LOAD_DONE and DUMP_DONE are never high in the same cycle.
// CONFIGURATION
//  SYSMEM_GEN_COUNT_EN defined:
//    - GEN_COUNT increments on every RUN edge.
//    - Wraps from 2^COUNT_WIDTH-1 to 0.
//    - Cleared only by reset.
//  Not defined: GEN_COUNT port absent; no counter logic.
// TESTING (DATA_SIZE=8, LANE_WIDTH=2, BEATS=4)
//  1. Pull RESET_N low mid-cycle with mem=8'hFF -> DATA_OUT=0, SERIAL_OUT=0, DONEs=0 before the next edge.
//  2. LOAD=1, SERIAL_IN 2'b10,01,11,00 over 4 edges -> DATA_OUT=8'b10011100.
//     LOAD_DONE high for exactly 1 cycle after edge 4.
//  3. RUN=LOAD=DUMP=1, GRID_IN=8'hA5, one edge -> DATA_OUT=8'hA5; no DONE pulse.
//  4. mem=8'hA5, DUMP=1 for 4 edges -> SERIAL_OUT before each edge: 10,10,01,01.
//     Then DATA_OUT=8'hA5 and DUMP_DONE pulses once.
//  5. LOAD 2 beats, 1 IDLE cycle, LOAD 4 beats -> LOAD_DONE only after the 4th beat of the second frame.
//  6. Macro defined, COUNT_WIDTH=2: 5 RUN edges -> GEN_COUNT=1 (wrapped).
//     Reset -> GEN_COUNT=0.

Source files
------------

// File: rtl/system_memory_v3.sv
// Grid state memory for the Conway engine: parallel RUN load, serial LOAD/DUMP lanes, frame-done pulses.
// Optional generation counter enabled by defining SYSMEM_GEN_COUNT_EN.
module system_memory_v3 #(
  parameter int DATA_SIZE   = 25,
  parameter int LANE_WIDTH  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [DATA_SIZE-1:0]   GRID_IN,
  input  logic [LANE_WIDTH-1:0]  SERIAL_IN,
  input  logic                   LOAD_MODE,
  input  logic                   RUN_MODE,
  input  logic                   DUMP_MODE,
  output logic [DATA_SIZE-1:0]   DATA_OUT,
  output logic [LANE_WIDTH-1:0]  SERIAL_OUT,
  output logic                   LOAD_DONE,
`ifdef SYSMEM_GEN_COUNT_EN
  output logic                   DUMP_DONE,
  output logic [COUNT_WIDTH-1:0] GEN_COUNT
`else
  output logic                   DUMP_DONE
`endif
);

  localparam int BEATS  = DATA_SIZE / LANE_WIDTH;
  localparam int BEAT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RUN  = 2'd1,
    OP_LOAD = 2'd2,
    OP_DUMP = 2'd3
  } op_e;

  op_e                  op_d, prev_op_q;
  logic [DATA_SIZE-1:0] mem_d, mem_q;
  logic [BEAT_W-1:0]    beat_d, beat_q;
  logic                 load_done_d, load_done_q;
  logic                 dump_done_d, dump_done_q;

  always_comb begin
    op_d = OP_IDLE;
    if (RUN_MODE)       op_d = OP_RUN;
    else if (LOAD_MODE) op_d = OP_LOAD;
    else if (DUMP_MODE) op_d = OP_DUMP;
  end

  always_comb begin
    mem_d       = mem_q;
    beat_d      = '0;
    load_done_d = 1'b0;
    dump_done_d = 1'b0;
    case (op_d)
      OP_RUN:  mem_d = GRID_IN;
      OP_LOAD: mem_d = {mem_q[DATA_SIZE-LANE_WIDTH-1:0], SERIAL_IN};
      OP_DUMP: mem_d = {mem_q[DATA_SIZE-LANE_WIDTH-1:0], mem_q[DATA_SIZE-1 -: LANE_WIDTH]};
      default: mem_d = mem_q;
    endcase
    // A frame is counted only while the same serial op is held; any change restarts at beat 1.
    if (op_d == OP_LOAD || op_d == OP_DUMP) begin
      if (prev_op_q != op_d) begin
        beat_d = BEAT_W'(1);
      end else if (beat_q == LAST_BEAT) begin
        beat_d      = '0;
        load_done_d = (op_d == OP_LOAD);
        dump_done_d = (op_d == OP_DUMP);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_q       <= '0;
      beat_q      <= '0;
      prev_op_q   <= OP_IDLE;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      beat_q      <= beat_d;
      prev_op_q   <= op_d;
      load_done_q <= load_done_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign DATA_OUT   = mem_q;
  assign SERIAL_OUT = mem_q[DATA_SIZE-1 -: LANE_WIDTH];
  assign LOAD_DONE  = load_done_q;
  assign DUMP_DONE  = dump_done_q;

`ifdef SYSMEM_GEN_COUNT_EN
  logic [COUNT_WIDTH-1:0] gen_d, gen_q;

  always_comb begin
    gen_d = gen_q;
    if (op_d == OP_RUN) gen_d = gen_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) gen_q <= '0;
    else          gen_q <= gen_d;
  end

  assign GEN_COUNT = gen_q;
`endif

endmodule

// File: tb/tb_system_memory_v3.sv
// Directed bench for system_memory_v3 with DATA_SIZE=8, LANE_WIDTH=2 (4 beats per frame).
// Define SYSMEM_GEN_COUNT_EN to also exercise the 2-bit generation counter.
module tb_system_memory_v3;
  localparam int DS = 8;
  localparam int LW = 2;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [DS-1:0] GRID_IN = '0;
  logic [LW-1:0] SERIAL_IN = '0;
  logic          LOAD_MODE = 1'b0;
  logic          RUN_MODE = 1'b0;
  logic          DUMP_MODE = 1'b0;
  logic [DS-1:0] DATA_OUT;
  logic [LW-1:0] SERIAL_OUT;
  logic          LOAD_DONE;
  logic          DUMP_DONE;
`ifdef SYSMEM_GEN_COUNT_EN
  logic [CW-1:0] GEN_COUNT;
`endif

  system_memory_v3 #(.DATA_SIZE(DS), .LANE_WIDTH(LW), .COUNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .GRID_IN(GRID_IN), .SERIAL_IN(SERIAL_IN),
    .LOAD_MODE(LOAD_MODE), .RUN_MODE(RUN_MODE), .DUMP_MODE(DUMP_MODE),
    .DATA_OUT(DATA_OUT), .SERIAL_OUT(SERIAL_OUT), .LOAD_DONE(LOAD_DONE),
`ifdef SYSMEM_GEN_COUNT_EN
    .DUMP_DONE(DUMP_DONE), .GEN_COUNT(GEN_COUNT)
`else
    .DUMP_DONE(DUMP_DONE)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too, half a cycle after the rising edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_modes(input logic r, input logic l, input logic d);
    RUN_MODE = r; LOAD_MODE = l; DUMP_MODE = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(DATA_OUT), 32'h0);
    check({tag, "_sout"}, 32'(SERIAL_OUT), 32'h0);
    check({tag, "_ldone"}, 32'(LOAD_DONE), 32'h0);
    check({tag, "_ddone"}, 32'(DUMP_DONE), 32'h0);
  endtask

  logic [LW-1:0] load_lanes [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
  logic [LW-1:0] dump_lanes [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
  logic [LW-1:0] load2_lanes[4] = '{2'b01, 2'b10, 2'b00, 2'b11};

  initial begin
    #2;
    check_reset_outputs("init_rst");
    @(negedge CLK);
    RESET_N = 1'b1;

    // Asynchronous reset mid-cycle with memory full of ones
    set_modes(1, 0, 0); GRID_IN = 8'hFF;
    step();
    check("run_ff", 32'(DATA_OUT), 32'hFF);
    check("run_ff_sout", 32'(SERIAL_OUT), 32'h3);
    set_modes(0, 0, 0);
    #2 RESET_N = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge CLK);
    RESET_N = 1'b1;

    // Serial load of one frame
    for (int i = 0; i < 4; i++) begin
      SERIAL_IN = load_lanes[i];
      set_modes(0, 1, 0);
      step();
      check($sformatf("load_done_b%0d", i + 1), 32'(LOAD_DONE), 32'(i == 3));
    end
    set_modes(0, 0, 0);
    step();
    check("load_data", 32'(DATA_OUT), 32'h9C);
    check("load_done_after", 32'(LOAD_DONE), 32'h0);

    // RUN wins over LOAD and DUMP
    set_modes(1, 1, 1); GRID_IN = 8'hA5;
    step();
    check("prio_data", 32'(DATA_OUT), 32'hA5);
    check("prio_ldone", 32'(LOAD_DONE), 32'h0);
    check("prio_ddone", 32'(DUMP_DONE), 32'h0);

    // Dump one frame, then hold DUMP for two more back-to-back frames
    for (int i = 0; i < 12; i++) begin
      set_modes(0, 0, 1);
      check($sformatf("dump_sout_e%0d", i + 1), 32'(SERIAL_OUT), 32'(dump_lanes[i % 4]));
      step();
      check($sformatf("dump_done_e%0d", i + 1), 32'(DUMP_DONE), 32'(i % 4 == 3));
      check($sformatf("dump_ldone_e%0d", i + 1), 32'(LOAD_DONE), 32'h0);
      if (i % 4 == 3) check($sformatf("dump_data_e%0d", i + 1), 32'(DATA_OUT), 32'hA5);
    end

    // Aborted load (2 beats), one idle cycle, then a full frame
    for (int i = 0; i < 2; i++) begin
      SERIAL_IN = 2'b11; set_modes(0, 1, 0);
      step();
      check($sformatf("abort_ldone_b%0d", i + 1), 32'(LOAD_DONE), 32'h0);
    end
    check("abort_data", 32'(DATA_OUT), 32'h5F);
    set_modes(0, 0, 0);
    step();
    check("idle_ldone", 32'(LOAD_DONE), 32'h0);
    check("idle_data", 32'(DATA_OUT), 32'h5F);
    for (int i = 0; i < 4; i++) begin
      SERIAL_IN = load2_lanes[i]; set_modes(0, 1, 0);
      step();
      check($sformatf("reload_done_b%0d", i + 1), 32'(LOAD_DONE), 32'(i == 3));
    end
    check("reload_data", 32'(DATA_OUT), 32'h63);

    // LOAD_DONE from the frame above is still high; switch straight from LOAD (2 beats) to DUMP
    for (int i = 0; i < 2; i++) begin
      SERIAL_IN = 2'b00; set_modes(0, 1, 0);
      step();
      check($sformatf("switch_ldone_b%0d", i + 1), 32'(LOAD_DONE), 32'h0);
    end
    check("switch_data", 32'(DATA_OUT), 32'h30);
    for (int i = 0; i < 4; i++) begin
      set_modes(0, 0, 1);
      step();
      check($sformatf("switch_ddone_e%0d", i + 1), 32'(DUMP_DONE), 32'(i == 3));
      check($sformatf("switch_ldone_e%0d", i + 1), 32'(LOAD_DONE), 32'h0);
    end
    check("switch_dump_data", 32'(DATA_OUT), 32'h30);

    // Reset while DUMP_DONE is high clears it at once
    set_modes(0, 0, 0);
    #2 RESET_N = 1'b0;
    #1 check_reset_outputs("rst_in_pulse");
    @(negedge CLK);
    RESET_N = 1'b1;

`ifdef SYSMEM_GEN_COUNT_EN
    check("gen_after_rst", 32'(GEN_COUNT), 32'h0);
    for (int i = 0; i < 5; i++) begin
      set_modes(1, 0, 0); GRID_IN = 8'(i);
      step();
      check($sformatf("gen_run%0d", i + 1), 32'(GEN_COUNT), 32'((i + 1) % 4));
    end
    set_modes(0, 0, 0);
    step();
    check("gen_hold", 32'(GEN_COUNT), 32'h1);
    #2 RESET_N = 1'b0;
    #1 check("gen_rst", 32'(GEN_COUNT), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
